spike_generator: RTL



---
 rtl/spike_generator.sv | 102 ++++++++++
 1 files changed

// File: rtl/spike_generator.sv
// Turns a per-window spike count into evenly spread one-clk spike pulses across
// the next slow_clk window, using a Bresenham-style accumulator modulo the measured period.
module spike_generator #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                slow_clk,
    input  logic [PERIOD_W-1:0] int_cnt_in,
    output logic                spike,
    output logic [PERIOD_W-1:0] spike_cnt_out,
    output logic [PERIOD_W-1:0] period_out,
    output logic                clamped,
    output logic                active
);

    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, RUN} state_t;

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    state_t              state, state_next;
    logic                slow_clk_reg;
    logic                slow_edge;
    logic [PERIOD_W-1:0] per_cnt;
    logic [PERIOD_W-1:0] p_lat;
    logic [PERIOD_W-1:0] n_eff;
    logic [PERIOD_W-1:0] acc;
    logic [PERIOD_W-1:0] emitted;
    logic [PERIOD_W-1:0] half;
    logic [PERIOD_W-1:0] n_req;
    logic [PERIOD_W:0]   sum;
    logic                overflow;

    assign slow_edge = slow_clk & ~slow_clk_reg;
    // Capping at P/2 keeps at least one low cycle between pulses.
    assign half      = per_cnt >> 1;
    assign n_req     = (int_cnt_in > half) ? half : int_cnt_in;
    assign sum       = {1'b0, acc} + {1'b0, n_eff};
    assign overflow  = (sum >= {1'b0, p_lat});
    assign active    = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_FIRST;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FIRST: if (slow_edge) state_next = MEASURE;
            MEASURE:    if (slow_edge) state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slow_clk_reg  <= 1'b0;
            per_cnt       <= '0;
            period_out    <= '0;
            p_lat         <= '0;
            n_eff         <= '0;
            acc           <= '0;
            emitted       <= '0;
            spike_cnt_out <= '0;
            clamped       <= 1'b0;
            spike         <= 1'b0;
        end else begin
            slow_clk_reg <= slow_clk;

            if (slow_edge) begin
                per_cnt    <= PERIOD_W'(1);
                period_out <= per_cnt;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + PERIOD_W'(1);
            end

            // An edge always wins over a pending overflow; leftover spikes are dropped.
            if (slow_edge && state_next == RUN) begin
                p_lat         <= per_cnt;
                n_eff         <= n_req;
                acc           <= n_req;
                clamped       <= (int_cnt_in > half);
                spike_cnt_out <= emitted;
                emitted       <= '0;
                spike         <= 1'b0;
            end else if (state == RUN && !slow_edge) begin
                if (overflow) begin
                    acc     <= sum[PERIOD_W-1:0] - p_lat;
                    spike   <= 1'b1;
                    emitted <= emitted + PERIOD_W'(1);
                end else begin
                    acc   <= sum[PERIOD_W-1:0];
                    spike <= 1'b0;
                end
            end else begin
                spike <= 1'b0;
            end
        end
    end

endmodule
